rover_nav_sequencer: RTL
========================

# rover_nav_sequencer

Clocked navigation sequencer for the line-following rover. It replaces the combinational sensor-to-motor mapping with a registered state machine. Inputs are the three inductive tape sensors, the proximity (cone) sensor and the red junction marker. It drives the two-motor H-bridge direction and enable lines, and sequences line following, junction stops, alternating junction turns, cone 180° turns and a timeout fault.

## Interface
- `DEB_CYC`, 4: consecutive stable samples needed before a synchronized input is accepted.
- `STOP_CYC`, 1000: cycles the motors are held off at a junction before the turn starts.
- `TURN_TMO`, 200000: maximum cycles in any turn state before `fault` is raised.
- `CNT_W`, 18: width of the shared cycle counter; must satisfy 2^CNT_W > max(`STOP_CYC`, `TURN_TMO`).
- `clk` in 1: single system clock; all logic rises on it.
- `reset_n` in 1: synchronous, active-low reset.
- `go` in 1: level; leaves IDLE when high, forces IDLE when low (except from FAULT).
- `induct` in 3: raw tape sensors {left, middle, right}, active-low (0 = on tape).
- `proxim` in 1: raw cone detect, active-high.
- `red` in 1: raw red-marker detect, active-high.
- `motor_in` out 4: H-bridge direction code.
- `motor_en` out 2: motor enables {left, right}.
- `state_o` out 3: current state encoding, for debug.
- `fault` out 1: sticky turn-timeout flag.

## Operation
- Input conditioning:
  - `induct`, `proxim` and `red` each pass through a 2-flop synchronizer, then a debouncer.
  - The debounced value updates only after `DEB_CYC` identical consecutive synchronized samples.
  - A rising edge of the debounced `red` produces a one-cycle `red_rise` pulse.
- Direction codes: FWD=4'b1001, LEFT=4'b0101, RIGHT=4'b1010, OFF=4'b0000.
- States (encoding in package): IDLE=0, FOLLOW=1, JSTOP=2, JTURN=3, CTURN=4, FAULT=5.
- IDLE:
  - Outputs OFF / 2'b00.
  - Go to FOLLOW when `go`=1.
- FOLLOW:
  - Motors enabled 2'b11. Direction comes from debounced `induct`:
    - 3'b001 or 3'b011 → LEFT.
    - 3'b100 or 3'b110 → RIGHT.
    - 3'b101 → FWD.
    - 3'b111 (off tape) → hold the previous direction.
  - Exits, highest priority first:
    - `proxim` → CTURN, with `cone_seen` set.
    - `induct`=3'b000 → JSTOP, counter cleared.
    - 3'b010 → hold the previous direction.
- JSTOP:
  - Outputs OFF / 2'b00.
  - After `STOP_CYC` cycles → JTURN, counter cleared.
- JTURN:
  - Enabled; direction is `dir_sel`: 0 = LEFT, 1 = RIGHT.
  - Exits when debounced `induct` has gone through 3'b111 and then reaches 3'b101 → FOLLOW.
- CTURN:
  - Enabled, RIGHT.
  - Same off-tape-then-reacquire exit as JTURN → FOLLOW.
- `red_rise`:
  - Toggles `dir_sel`.
  - If `cone_seen`=1, clear it and toggle `dir_sel` once more, so the branch already tried is re-entered from the other side.
  - Honoured in any state except IDLE and FAULT.
- Timeout: if the counter reaches `TURN_TMO` in JTURN or CTURN → FAULT.
- FAULT:
  - Outputs OFF / 2'b00, `fault`=1.
  - Exited only by reset.
- `go`=0 in any state except FAULT → IDLE next cycle. `dir_sel` and `cone_seen` are kept.
- Counter: CNT_W bits, saturating, cleared on every state entry.

## Timing
- Reset (`reset_n`=0 at a clk edge):
  - State IDLE, `motor_in`=4'b0000, `motor_en`=2'b00, `fault`=0.
  - `dir_sel`=0, `cone_seen`=0.
  - Synchronizers and debouncers cleared to the inactive level: `induct`=3'b111, `proxim`=0, `red`=0.
  - Reset mid-turn aborts the turn immediately.
- Outputs are registered and change on the edge after the state or decision changes.
- Raw-input-to-motor latency: 2 (sync) + `DEB_CYC` + 1 (output register) cycles; 7 at default.
- JSTOP lasts exactly `STOP_CYC` cycles with the motors off.
- Simultaneous events:
  - `proxim` and `induct`=3'b000 in the same cycle → CTURN.
  - `red_rise` in the same cycle as a state change → the toggle applies, and the new state uses the updated `dir_sel` on the following cycle.

## Structure
- Package `rover_pkg`:
  - State enum.
  - Direction localparams FWD/LEFT/RIGHT/OFF.
  - Sensor pattern constants: ON_LEFT, ON_RIGHT, CENTER, JUNCTION, OFF_TAPE.
- Sub-module `sync_debounce`: parameterized width and `DEB_CYC`. One instance each for `induct`, `proxim` and `red`.
- FSM, counter and output register live in the top module.

## Test plan
- Reset, then `go`=1 with raw `induct`=3'b101 held → `motor_in`=4'b1001, `motor_en`=2'b11 exactly 7 cycles after the input settles; before that, outputs stay 0.
- Raw `induct`=3'b000 for 8 cycles → JSTOP with `motor_en`=00 for exactly `STOP_CYC` (set to 20); then JTURN with LEFT. Feed 111 then 101 → FOLLOW, FWD.
- Two `red` pulses (each 6 cycles high), then a junction → turn direction is LEFT after the 2nd pulse. A 3rd pulse gives RIGHT.
- `proxim`=1 during FOLLOW → RIGHT spin. A subsequent `red` pulse leaves `dir_sel` unchanged (double toggle) and `cone_seen` is cleared.
- JTURN with `induct` stuck at 3'b010 and `TURN_TMO`=50 → `fault`=1 and outputs OFF after 50 cycles. `go` toggling has no effect; only `reset_n`=0 clears it.
- Glitch test: a 3-cycle `red` pulse → no toggle. `reset_n` asserted mid-CTURN → IDLE with outputs 0 on the next edge.

Source files
------------

// File: rtl/rover_pkg.sv
// Shared types and constants for the rover navigation sequencer.
// Sensor patterns are active-low: a 0 bit means that sensor sits over the tape.
package rover_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FOLLOW = 3'd1,
        JSTOP  = 3'd2,
        JTURN  = 3'd3,
        CTURN  = 3'd4,
        FAULT  = 3'd5
    } state_t;

    localparam logic [3:0] FWD   = 4'b1001;
    localparam logic [3:0] LEFT  = 4'b0101;
    localparam logic [3:0] RIGHT = 4'b1010;
    localparam logic [3:0] OFF   = 4'b0000;

    localparam logic [2:0] ON_LEFT  = 3'b011;
    localparam logic [2:0] ON_RIGHT = 3'b110;
    localparam logic [2:0] CENTER   = 3'b101;
    localparam logic [2:0] JUNCTION = 3'b000;
    localparam logic [2:0] OFF_TAPE = 3'b111;

    // Steer toward whichever side still sees tape; ambiguous patterns keep the last heading.
    function automatic logic [3:0] follow_dir(input logic [2:0] induct, input logic [3:0] prev);
        case (induct)
            3'b001, ON_LEFT:  follow_dir = LEFT;
            3'b100, ON_RIGHT: follow_dir = RIGHT;
            CENTER:           follow_dir = FWD;
            default:          follow_dir = prev;
        endcase
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a debouncer: the output only moves once
// DEB_CYC identical consecutive synchronized samples have been seen.
module sync_debounce #(
    parameter int             W       = 1,
    parameter int             DEB_CYC = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int            CW      = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(DEB_CYC);

    logic [W-1:0]  sync1, sync2, prev;
    logic [CW-1:0] run, run_next;

    // Length of the current run of identical samples, saturating at DEB_CYC.
    always_comb begin
        run_next = CW'(1);
        if (sync2 == prev) begin
            run_next = (run == RUN_MAX) ? run : run + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
            prev  <= RST_VAL;
            dout  <= RST_VAL;
            run   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
            run   <= run_next;
            if (run_next == RUN_MAX) begin
                dout <= sync2;
            end
        end
    end

endmodule

// File: rtl/rover_nav_sequencer.sv
// Registered navigation FSM for the line-following rover: line following,
// timed junction stops, alternating junction turns, cone U-turns and a turn timeout.
module rover_nav_sequencer
    import rover_pkg::*;
#(
    parameter int DEB_CYC  = 4,
    parameter int STOP_CYC = 1000,
    parameter int TURN_TMO = 200000,
    parameter int CNT_W    = 18
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    input  logic [2:0] induct,
    input  logic       proxim,
    input  logic       red,
    output logic [3:0] motor_in,
    output logic [1:0] motor_en,
    output logic [2:0] state_o,
    output logic       fault
);

    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TURN_TMO - 1);

    logic [2:0]       ind_db;
    logic             prox_db, red_db, red_q, red_rise;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             dir_sel, dir_sel_next;
    logic             cone_seen, cone_seen_next;
    logic             seen_off, seen_off_next;
    logic [3:0]       dir_next;
    logic [1:0]       en_next;

    sync_debounce #(.W(3), .DEB_CYC(DEB_CYC), .RST_VAL(OFF_TAPE)) u_induct (
        .clk(clk), .reset_n(reset_n), .din(induct), .dout(ind_db)
    );
    sync_debounce #(.W(1), .DEB_CYC(DEB_CYC), .RST_VAL(1'b0)) u_proxim (
        .clk(clk), .reset_n(reset_n), .din(proxim), .dout(prox_db)
    );
    sync_debounce #(.W(1), .DEB_CYC(DEB_CYC), .RST_VAL(1'b0)) u_red (
        .clk(clk), .reset_n(reset_n), .din(red), .dout(red_db)
    );

    assign red_rise = red_db & ~red_q;
    assign state_o  = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (go) state_next = FOLLOW;
            FOLLOW: begin
                if (prox_db)                 state_next = CTURN;
                else if (ind_db == JUNCTION) state_next = JSTOP;
            end
            JSTOP:  if (cnt >= STOP_LAST) state_next = JTURN;
            // A turn ends only after the sensors leave the tape and then re-centre.
            JTURN, CTURN: begin
                if (seen_off && ind_db == CENTER) state_next = FOLLOW;
                else if (cnt >= TMO_LAST)         state_next = FAULT;
            end
            FAULT:  state_next = FAULT;
            default: state_next = IDLE;
        endcase
        if (!go && state != FAULT) state_next = IDLE;

        // After a cone the branch was already tried, so the marker leaves the turn side unchanged.
        dir_sel_next   = dir_sel;
        cone_seen_next = cone_seen;
        if (red_rise && state != IDLE && state != FAULT) begin
            if (cone_seen) cone_seen_next = 1'b0;
            else           dir_sel_next   = ~dir_sel;
        end
        if (state == FOLLOW && state_next == CTURN) cone_seen_next = 1'b1;

        if (state_next != state) begin
            cnt_next      = '0;
            seen_off_next = 1'b0;
        end else begin
            cnt_next      = (&cnt) ? cnt : cnt + CNT_W'(1);
            seen_off_next = seen_off | (ind_db == OFF_TAPE);
        end

        dir_next = OFF;
        en_next  = 2'b00;
        case (state)
            FOLLOW: begin
                en_next  = 2'b11;
                dir_next = follow_dir(ind_db, motor_in);
            end
            JTURN: begin
                en_next  = 2'b11;
                dir_next = dir_sel ? RIGHT : LEFT;
            end
            CTURN: begin
                en_next  = 2'b11;
                dir_next = RIGHT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dir_sel   <= 1'b0;
            cone_seen <= 1'b0;
            seen_off  <= 1'b0;
            red_q     <= 1'b0;
            motor_in  <= OFF;
            motor_en  <= 2'b00;
            fault     <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            dir_sel   <= dir_sel_next;
            cone_seen <= cone_seen_next;
            seen_off  <= seen_off_next;
            red_q     <= red_db;
            motor_in  <= dir_next;
            motor_en  <= en_next;
            fault     <= fault | (state == FAULT);
        end
    end

endmodule
